lcd_ctrl_4bit: RTL and testbench

- Parametrised HD44780-compatible character-LCD controller for the 4-bit SF_D[11:8] bus.
- After reset it performs the full power-on init sequence autonomously, with all delays derived from CLK_HZ.
- It then accepts arbitrary command/data bytes over a valid/ready handshake and serialises each byte as two nibbles with correct E timing and execution waits.
- It sits between display-content logic (text writers, cursor control) and the LCD pins.

---
 rtl/lcd_ctrl_4bit_pkg.sv | 26 ++
 rtl/lcd_ctrl_4bit_if.sv | 10 +
 rtl/lcd_ctrl_4bit_strobe.sv | 82 ++++++++
 rtl/lcd_ctrl_4bit.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_ctrl_4bit.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_ctrl_4bit_pkg.sv
// Shared definitions for the 4-bit HD44780 controller: sequencer state codes,
// instruction opcodes and the time-to-cycles conversion.
package lcd_pkg;

    localparam logic [3:0] PWR_WAIT  = 4'd0;
    localparam logic [3:0] INIT_NIB  = 4'd1;
    localparam logic [3:0] INIT_WAIT = 4'd2;
    localparam logic [3:0] CFG_LOAD  = 4'd3;
    localparam logic [3:0] HI_NIB    = 4'd4;
    localparam logic [3:0] GAP       = 4'd5;
    localparam logic [3:0] LO_NIB    = 4'd6;
    localparam logic [3:0] EXEC_WAIT = 4'd7;
    localparam logic [3:0] IDLE      = 4'd8;

    localparam logic [7:0] CLEAR   = 8'h01;
    localparam logic [7:0] HOME    = 8'h02;
    localparam logic [7:0] ENTRY   = 8'h04;
    localparam logic [7:0] DISPLAY = 8'h08;
    localparam logic [7:0] FUNCSET = 8'h20;

    // Cycles needed to cover t_ns nanoseconds at clk_hz, rounded up.
    function automatic int unsigned cyc(input longint unsigned t_ns, input longint unsigned clk_hz);
        return 32'((t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/lcd_ctrl_4bit_if.sv
// Command byte handshake between display-content logic and the LCD controller.
interface lcd_ctrl_4bit_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_RS;
    logic [7:0] CMD_DATA;

    modport master (output CMD_VALID, output CMD_RS, output CMD_DATA, input CMD_READY);
    modport slave  (input CMD_VALID, input CMD_RS, input CMD_DATA, output CMD_READY);
endinterface

// File: rtl/lcd_ctrl_4bit_strobe.sv
// One nibble write: data/RS set up for T_SU cycles, E high for T_EW cycles,
// then one hold cycle during which done_o is high.
module lcd_nibble_strobe #(
    parameter int unsigned T_SU = 2,
    parameter int unsigned T_EW = 12
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] nib_i,
    input  logic       rs_i,
    output logic [3:0] sf_d_o,
    output logic       e_o,
    output logic       rs_o,
    output logic       done_o
);
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_SU   = 2'd1;
    localparam logic [1:0] P_HIGH = 2'd2;
    localparam logic [1:0] P_HOLD = 2'd3;

    localparam int unsigned SMAX = (T_SU > T_EW) ? T_SU : T_EW;
    localparam int unsigned SW   = $clog2(SMAX + 1);

    logic [1:0]    ph_q, ph_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [3:0]    nib_q, nib_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;

    always_comb begin
        ph_d  = ph_q;
        cnt_d = cnt_q;
        nib_d = nib_q;
        rs_d  = rs_q;
        e_d   = e_q;
        case (ph_q)
            P_IDLE: if (start_i) begin
                nib_d = nib_i;
                rs_d  = rs_i;
                cnt_d = SW'(T_SU - 1);
                ph_d  = P_SU;
            end
            P_SU: if (cnt_q == '0) begin
                e_d   = 1'b1;
                cnt_d = SW'(T_EW - 1);
                ph_d  = P_HIGH;
            end else begin
                cnt_d = cnt_q - SW'(1);
            end
            P_HIGH: if (cnt_q == '0) begin
                e_d  = 1'b0;
                ph_d = P_HOLD;
            end else begin
                cnt_d = cnt_q - SW'(1);
            end
            default: ph_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q  <= P_IDLE;
            cnt_q <= '0;
            nib_q <= '0;
            rs_q  <= 1'b0;
            e_q   <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            nib_q <= nib_d;
            rs_q  <= rs_d;
            e_q   <= e_d;
        end
    end

    assign sf_d_o = nib_q;
    assign e_o    = e_q;
    assign rs_o   = rs_q;
    assign done_o = (ph_q == P_HOLD);

endmodule

// File: rtl/lcd_ctrl_4bit.sv
// HD44780 4-bit controller: autonomous power-on init, then byte writes over a
// valid/ready handshake, each split into two nibble strobes plus an execution wait.
module lcd_ctrl_4bit
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned POWERUP_US = 15000,
    parameter int unsigned LINES      = 2,
    parameter int unsigned FONT_5X10  = 0,
    parameter int unsigned ENTRY_INC  = 1,
    parameter int unsigned CURSOR_ON  = 0,
    parameter int unsigned BLINK_ON   = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    lcd_ctrl_4bit_if.slave        cmd,
    output logic                  INIT_DONE,
    output logic [3:0]            SF_D,
    output logic                  LCD_E,
    output logic                  LCD_RS,
    output logic                  LCD_RW
);
    localparam int unsigned T_PWR   = cyc(64'(POWERUP_US) * 64'd1000, CLK_HZ);
    localparam int unsigned T_4MS1  = cyc(4_100_000, CLK_HZ);
    localparam int unsigned T_100US = cyc(100_000, CLK_HZ);
    localparam int unsigned T_40US  = cyc(40_000, CLK_HZ);
    localparam int unsigned T_SU    = cyc(40, CLK_HZ);
    localparam int unsigned T_EW    = cyc(240, CLK_HZ);
    localparam int unsigned T_GAP   = cyc(1000, CLK_HZ);
    localparam int unsigned T_CLR   = cyc(1_640_000, CLK_HZ);

    localparam int unsigned T_MAX1 = (T_PWR > T_4MS1) ? T_PWR : T_4MS1;
    localparam int unsigned T_MAX  = (T_MAX1 > T_CLR) ? T_MAX1 : T_CLR;
    localparam int unsigned CW     = $clog2(T_MAX + 1);

    // Waits run from the E fall to the next nibble drive (or READY). The counter
    // is loaded on the hold cycle after E falls, hence -2; paths that pass
    // through CFG_LOAD spend one more cycle there, hence -3.
    localparam logic [CW-1:0] L_PWR      = CW'(T_PWR - 1);
    localparam logic [CW-1:0] L_4MS1     = CW'(T_4MS1 - 2);
    localparam logic [CW-1:0] L_100US    = CW'(T_100US - 2);
    localparam logic [CW-1:0] L_40US     = CW'(T_40US - 2);
    localparam logic [CW-1:0] L_40US_CFG = CW'(T_40US - 3);
    localparam logic [CW-1:0] L_CLR      = CW'(T_CLR - 2);
    localparam logic [CW-1:0] L_GAP      = CW'(T_GAP - T_SU - 2);

    localparam logic [7:0] FUNCSET_B = FUNCSET | ((LINES == 2) ? 8'h08 : 8'h00)
                                     | ((FONT_5X10 != 0) ? 8'h04 : 8'h00);
    localparam logic [7:0] ENTRY_B   = ENTRY | ((ENTRY_INC != 0) ? 8'h02 : 8'h00);
    localparam logic [7:0] DISP_B    = DISPLAY | 8'h04 | ((CURSOR_ON != 0) ? 8'h02 : 8'h00)
                                     | ((BLINK_ON != 0) ? 8'h01 : 8'h00);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [1:0]    cfg_idx_q, cfg_idx_d;
    logic          cfg_mode_q, cfg_mode_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic          stb_start, stb_rs, stb_done;
    logic [3:0]    stb_nib;
    logic [7:0]    cfg_byte;
    logic [CW-1:0] init_load;
    logic          exec_long;

    always_comb begin
        case (cfg_idx_q)
            2'd0:    cfg_byte = FUNCSET_B;
            2'd1:    cfg_byte = ENTRY_B;
            2'd2:    cfg_byte = DISP_B;
            default: cfg_byte = CLEAR;
        endcase
        case (init_idx_q)
            2'd0:    init_load = L_4MS1;
            2'd1:    init_load = L_100US;
            2'd2:    init_load = L_40US;
            default: init_load = L_40US_CFG;
        endcase
    end

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    assign exec_long = !rs_q && (byte_q[7:2] == 6'd0) && (byte_q != 8'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        cfg_idx_d  = cfg_idx_q;
        cfg_mode_d = cfg_mode_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        ready_d    = ready_q;
        done_d     = done_q;
        stb_start  = 1'b0;
        stb_nib    = '0;
        stb_rs     = 1'b0;
        case (state_q)
            // The counter is zero out of reset, so the power-up wait counts up.
            PWR_WAIT: if (cnt_q == L_PWR) begin
                cnt_d      = '0;
                stb_start  = 1'b1;
                stb_nib    = 4'h3;
                init_idx_d = '0;
                state_d    = INIT_NIB;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            INIT_NIB: if (stb_done) begin
                cnt_d   = init_load;
                state_d = INIT_WAIT;
            end
            INIT_WAIT: if (cnt_q == '0) begin
                if (init_idx_q == 2'd3) begin
                    cfg_idx_d  = '0;
                    cfg_mode_d = 1'b1;
                    state_d    = CFG_LOAD;
                end else begin
                    init_idx_d = init_idx_q + 2'd1;
                    stb_start  = 1'b1;
                    stb_nib    = (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
                    state_d    = INIT_NIB;
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            CFG_LOAD: begin
                byte_d    = cfg_byte;
                rs_d      = 1'b0;
                stb_start = 1'b1;
                stb_nib   = cfg_byte[7:4];
                state_d   = HI_NIB;
            end
            HI_NIB: if (stb_done) begin
                cnt_d   = L_GAP;
                state_d = GAP;
            end
            GAP: if (cnt_q == '0) begin
                stb_start = 1'b1;
                stb_nib   = byte_q[3:0];
                stb_rs    = rs_q;
                state_d   = LO_NIB;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            LO_NIB: if (stb_done) begin
                if (exec_long)
                    cnt_d = L_CLR;
                else if (cfg_mode_q && cfg_idx_q != 2'd3)
                    cnt_d = L_40US_CFG;
                else
                    cnt_d = L_40US;
                state_d = EXEC_WAIT;
            end
            EXEC_WAIT: if (cnt_q == '0) begin
                if (cfg_mode_q && cfg_idx_q != 2'd3) begin
                    cfg_idx_d = cfg_idx_q + 2'd1;
                    state_d   = CFG_LOAD;
                end else begin
                    if (cfg_mode_q)
                        done_d = 1'b1;
                    cfg_mode_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = IDLE;
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            IDLE: if (cmd.CMD_VALID && ready_q) begin
                byte_d    = cmd.CMD_DATA;
                rs_d      = cmd.CMD_RS;
                ready_d   = 1'b0;
                stb_start = 1'b1;
                stb_nib   = cmd.CMD_DATA[7:4];
                stb_rs    = cmd.CMD_RS;
                state_d   = HI_NIB;
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= PWR_WAIT;
            cnt_q      <= '0;
            init_idx_q <= '0;
            cfg_idx_q  <= '0;
            cfg_mode_q <= 1'b0;
            byte_q     <= '0;
            rs_q       <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            cfg_idx_q  <= cfg_idx_d;
            cfg_mode_q <= cfg_mode_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    lcd_nibble_strobe #(
        .T_SU (T_SU),
        .T_EW (T_EW)
    ) u_strobe (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .start_i (stb_start),
        .nib_i   (stb_nib),
        .rs_i    (stb_rs),
        .sf_d_o  (SF_D),
        .e_o     (LCD_E),
        .rs_o    (LCD_RS),
        .done_o  (stb_done)
    );

    assign cmd.CMD_READY = ready_q;
    assign INIT_DONE     = done_q;
    assign LCD_RW        = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl_4bit.sv
// Directed bench for lcd_ctrl_4bit at 5 MHz with a 1 ms power-up wait.
module tb_lcd_ctrl_4bit;
    localparam int unsigned CLK_HZ     = 5_000_000;
    localparam int unsigned POWERUP_US = 1000;
    // Cycle counts worked out by hand for 5 MHz.
    localparam int T_PWR   = 5000;
    localparam int T_4MS1  = 20500;
    localparam int T_100US = 500;
    localparam int T_40US  = 200;
    localparam int T_SU    = 1;
    localparam int T_EW    = 2;
    localparam int T_GAP   = 5;
    localparam int T_CLR   = 8200;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    lcd_ctrl_4bit_if cmd();
    logic       INIT_DONE;
    logic [3:0] SF_D;
    logic       LCD_E, LCD_RS, LCD_RW;

    lcd_ctrl_4bit #(
        .CLK_HZ     (CLK_HZ),
        .POWERUP_US (POWERUP_US)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd       (cmd),
        .INIT_DONE (INIT_DONE),
        .SF_D      (SF_D),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW)
    );

    typedef struct {
        int         rise;
        int         fall;
        logic [3:0] nib;
        logic       rs;
    } pulse_t;

    pulse_t pq[$];
    pulse_t cur;
    pulse_t tmp;
    int     ncyc = 0;
    int     ready_rise = 0;
    int     done_rise = 0;
    int     ready_viol = 0;
    logic   prev_e = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    int     pass_cnt = 0;
    int     total = 0;

    // ncyc = number of rising edges since reset release
    always @(posedge CLK or negedge RST_N)
        if (!RST_N) ncyc <= 0;
        else        ncyc <= ncyc + 1;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_e     <= 1'b0;
            prev_ready <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (LCD_E && !prev_e) begin
                cur.rise <= ncyc;
                cur.nib  <= SF_D;
                cur.rs   <= LCD_RS;
            end
            if (!LCD_E && prev_e) begin
                tmp = cur;
                tmp.fall = ncyc;
                pq.push_back(tmp);
            end
            if (cmd.CMD_READY && !prev_ready) ready_rise <= ncyc;
            if (INIT_DONE && !prev_done)      done_rise  <= ncyc;
            if (cmd.CMD_READY && !INIT_DONE)  ready_viol <= ready_viol + 1;
            prev_e     <= LCD_E;
            prev_ready <= cmd.CMD_READY;
            prev_done  <= INIT_DONE;
        end
    end

    task automatic send_byte(input logic rs, input logic [7:0] d, output int acc);
        acc = -1;
        @(negedge CLK);
        cmd.CMD_RS = rs; cmd.CMD_DATA = d; cmd.CMD_VALID = 1'b1;
        for (int i = 0; i < 20000 && acc < 0; i++) begin
            if (cmd.CMD_READY) begin
                @(posedge CLK); #1;
                acc = ncyc;
            end else begin
                @(negedge CLK);
            end
        end
        @(negedge CLK);
        cmd.CMD_VALID = 1'b0; cmd.CMD_DATA = 8'hEE; cmd.CMD_RS = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge CLK); #1;
            if (cmd.CMD_READY) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        cmd.CMD_VALID = 1'b1; cmd.CMD_RS = 1'b1; cmd.CMD_DATA = 8'hFF;
        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({SF_D, LCD_E, LCD_RS, LCD_RW, cmd.CMD_READY, INIT_DONE} !== 9'b0)
            $display("FAIL reset_outputs: got %b required 000000000",
                     {SF_D, LCD_E, LCD_RS, LCD_RW, cmd.CMD_READY, INIT_DONE});
        else pass_cnt++;
        @(negedge CLK);
        pq.delete();
        RST_N = 1'b1;
    endtask

    task automatic test_init();
        logic [3:0] en [12];
        int         sp [6];
        int         sp_idx [6];
        en = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        sp = '{T_4MS1 + T_SU, T_100US + T_SU, T_40US + T_SU, T_40US + T_SU, T_GAP, T_40US + T_SU};
        sp_idx = '{1, 2, 3, 4, 5, 6};
        for (int i = 0; i < 40000 && !INIT_DONE; i++) @(negedge CLK);
        cmd.CMD_VALID = 1'b0;
        total++;
        if (INIT_DONE !== 1'b1) $display("FAIL init_done_timeout: got %b required 1", INIT_DONE);
        else pass_cnt++;
        repeat (20) @(negedge CLK);
        #1;
        total++;
        if (ready_viol !== 0) $display("FAIL ready_during_init: got %0d cycles required 0", ready_viol);
        else pass_cnt++;
        total++;
        if (pq.size() !== 12) $display("FAIL init_pulse_count: got %0d required 12", pq.size());
        else pass_cnt++;
        if (pq.size() >= 12) begin
            total++;
            if (pq[0].rise !== T_PWR + T_SU)
                $display("FAIL first_e_rise: got %0d required %0d", pq[0].rise, T_PWR + T_SU);
            else pass_cnt++;
            for (int i = 0; i < 12; i++) begin
                total++;
                if ({pq[i].rs, pq[i].nib} !== {1'b0, en[i]})
                    $display("FAIL init_nibble_%0d: got rs=%b nib=%h required rs=0 nib=%h",
                             i, pq[i].rs, pq[i].nib, en[i]);
                else pass_cnt++;
                total++;
                if (pq[i].fall - pq[i].rise !== T_EW)
                    $display("FAIL e_width_%0d: got %0d required %0d", i, pq[i].fall - pq[i].rise, T_EW);
                else pass_cnt++;
            end
            for (int k = 0; k < 6; k++) begin
                total++;
                if (pq[sp_idx[k]].rise - pq[sp_idx[k] - 1].fall !== sp[k])
                    $display("FAIL init_spacing_%0d: got %0d required %0d", sp_idx[k],
                             pq[sp_idx[k]].rise - pq[sp_idx[k] - 1].fall, sp[k]);
                else pass_cnt++;
            end
            total++;
            if (done_rise - pq[11].fall !== T_CLR)
                $display("FAIL init_done_delay: got %0d required %0d", done_rise - pq[11].fall, T_CLR);
            else pass_cnt++;
        end
        total++;
        if (ready_rise !== done_rise)
            $display("FAIL ready_with_done: got ready at %0d required %0d", ready_rise, done_rise);
        else pass_cnt++;
    endtask

    task automatic test_data_write();
        int acc;
        bit ok;
        pq.delete();
        send_byte(1'b1, 8'h41, acc);
        total++;
        if (acc < 0) $display("FAIL data_accept: got no transfer required one");
        else pass_cnt++;
        wait_ready(1000, ok);
        total++;
        if (ok !== 1'b1) $display("FAIL data_ready_timeout: got READY=0 required 1");
        else pass_cnt++;
        total++;
        if (pq.size() !== 2) $display("FAIL data_pulse_count: got %0d required 2", pq.size());
        else pass_cnt++;
        if (pq.size() >= 2) begin
            total++;
            if ({pq[0].rs, pq[0].nib, pq[1].rs, pq[1].nib} !== 10'b1_0100_1_0001)
                $display("FAIL data_nibbles: got %b%h %b%h required 14 11",
                         pq[0].rs, pq[0].nib, pq[1].rs, pq[1].nib);
            else pass_cnt++;
            total++;
            if (pq[0].rise - acc !== T_SU)
                $display("FAIL data_first_e: got %0d required %0d", pq[0].rise - acc, T_SU);
            else pass_cnt++;
            total++;
            if (pq[1].rise - pq[0].fall !== T_GAP)
                $display("FAIL data_gap: got %0d required %0d", pq[1].rise - pq[0].fall, T_GAP);
            else pass_cnt++;
            total++;
            if (ready_rise - pq[1].fall !== T_40US)
                $display("FAIL data_exec_wait: got %0d required %0d", ready_rise - pq[1].fall, T_40US);
            else pass_cnt++;
        end
    endtask

    task automatic test_exec_waits();
        logic       rsv [4];
        logic [7:0] dv  [4];
        int         wv  [4];
        int         acc;
        bit         ok;
        rsv = '{1'b0, 1'b0, 1'b0, 1'b1};
        dv  = '{8'h02, 8'h80, 8'h00, 8'h01};
        wv  = '{T_CLR, T_40US, T_40US, T_40US};
        for (int k = 0; k < 4; k++) begin
            pq.delete();
            send_byte(rsv[k], dv[k], acc);
            wait_ready(10000, ok);
            total++;
            if (pq.size() !== 2 || !ok)
                $display("FAIL exec_%h_pulses: got %0d pulses ready=%b required 2 pulses ready=1",
                         dv[k], pq.size(), ok);
            else pass_cnt++;
            if (pq.size() >= 2) begin
                total++;
                if (ready_rise - pq[1].fall !== wv[k])
                    $display("FAIL exec_wait_rs%b_%h: got %0d required %0d",
                             rsv[k], dv[k], ready_rise - pq[1].fall, wv[k]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] items [3];
        int         acc [3];
        int         n;
        bit         ok;
        items = '{8'h48, 8'h49, 8'h21};
        acc = '{0, 0, 0};
        n = 0;
        pq.delete();
        @(negedge CLK);
        for (int c = 0; c < 3000 && n < 3; c++) begin
            cmd.CMD_VALID = 1'b1;
            if (cmd.CMD_READY) begin
                cmd.CMD_RS = 1'b1; cmd.CMD_DATA = items[n];
                @(posedge CLK); #1;
                acc[n] = ncyc;
                n++;
            end else begin
                cmd.CMD_RS = 1'b0; cmd.CMD_DATA = 8'hEE ^ 8'(c);
            end
            @(negedge CLK);
        end
        cmd.CMD_VALID = 1'b0;
        wait_ready(1000, ok);
        total++;
        if (n !== 3 || !ok) $display("FAIL b2b_accepts: got %0d ready=%b required 3 ready=1", n, ok);
        else pass_cnt++;
        total++;
        if (pq.size() !== 6) $display("FAIL b2b_pulse_count: got %0d required 6", pq.size());
        else pass_cnt++;
        if (pq.size() >= 6) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({pq[2*i].rs, pq[2*i+1].rs, pq[2*i].nib, pq[2*i+1].nib} !== {2'b11, items[i]})
                    $display("FAIL b2b_byte_%0d: got rs=%b%b data=%h%h required rs=11 data=%h", i,
                             pq[2*i].rs, pq[2*i+1].rs, pq[2*i].nib, pq[2*i+1].nib, items[i]);
                else pass_cnt++;
            end
            total++;
            if (acc[1] - pq[1].fall !== T_40US + 1)
                $display("FAIL b2b_accept_1: got %0d required %0d", acc[1] - pq[1].fall, T_40US + 1);
            else pass_cnt++;
            total++;
            if (pq[4].rise - pq[3].fall !== T_40US + 1 + T_SU)
                $display("FAIL b2b_spacing_2: got %0d required %0d", pq[4].rise - pq[3].fall, T_40US + 1 + T_SU);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int  acc;
        bit  hit;
        hit = 1'b0;
        pq.delete();
        send_byte(1'b1, 8'h5A, acc);
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge CLK); #1;
            if (LCD_E && pq.size() == 1) hit = 1'b1;
        end
        total++;
        if (!hit) $display("FAIL mid_low_nibble_timeout: got no low-nibble E required one");
        else pass_cnt++;
        total++;
        if (SF_D !== 4'hA) $display("FAIL mid_low_nibble_value: got %h required a", SF_D);
        else pass_cnt++;
        RST_N = 1'b0;
        #1;
        total++;
        if ({LCD_E, SF_D, LCD_RS, cmd.CMD_READY} !== 7'b0)
            $display("FAIL async_reset_outputs: got %b required 0000000", {LCD_E, SF_D, LCD_RS, cmd.CMD_READY});
        else pass_cnt++;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        pq.delete();
        RST_N = 1'b1;
        for (int i = 0; i < 6000 && pq.size() == 0; i++) begin
            @(negedge CLK); #1;
        end
        total++;
        if (pq.size() == 0) $display("FAIL reinit_timeout: got no E pulse required one");
        else if (pq[0].rise !== T_PWR + T_SU || pq[0].nib !== 4'h3)
            $display("FAIL reinit_first_e: got cycle %0d nib %h required cycle %0d nib 3",
                     pq[0].rise, pq[0].nib, T_PWR + T_SU);
        else pass_cnt++;
        total++;
        if ({INIT_DONE, cmd.CMD_READY} !== 2'b00)
            $display("FAIL reinit_flags: got %b required 00", {INIT_DONE, cmd.CMD_READY});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_data_write();
        test_exec_waits();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
